// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional performance counters are enabled with the PC_PERF_EN macro.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ,
    PC_SEL_BR,
    PC_SEL_J,
    PC_SEL_JR
  } pc_sel_t;

  localparam int INSTR_BYTES  = 4;
  localparam int JUMP_INDEX_W = 26;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-side bundle between decode/branch logic and the PC sequencer.
// The counter signals exist only when PC_PERF_EN is defined.
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef PC_PERF_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) ();

  logic                    stall;
  logic                    branch_taken;
  logic [DATA_WIDTH-1:0]   branch_offset;
  logic                    jump;
  logic [JUMP_INDEX_W-1:0] jump_index;
  logic                    jump_reg;
  logic [DATA_WIDTH-1:0]   jr_addr;
  logic [DATA_WIDTH-1:0]   PC;
  logic [DATA_WIDTH-1:0]   PC_plus4;
  logic                    addr_err;
`ifdef PC_PERF_EN
  logic [CNT_WIDTH-1:0]    retired_cnt;
  logic [CNT_WIDTH-1:0]    redirect_cnt;
`endif

  modport master (
    output stall, branch_taken, branch_offset, jump, jump_index, jump_reg, jr_addr,
`ifdef PC_PERF_EN
    input  retired_cnt, redirect_cnt,
`endif
    input  PC, PC_plus4, addr_err
  );

  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_index, jump_reg, jr_addr,
`ifdef PC_PERF_EN
    output retired_cnt, redirect_cnt,
`endif
    output PC, PC_plus4, addr_err
  );

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Combinational next-PC selection: priority encode, target mux and misaligned-JR detect.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   pc_i,
  input  logic                    stall_i,
  input  logic                    branch_taken_i,
  input  logic [DATA_WIDTH-1:0]   branch_offset_i,
  input  logic                    jump_i,
  input  logic [JUMP_INDEX_W-1:0] jump_index_i,
  input  logic                    jump_reg_i,
  input  logic [DATA_WIDTH-1:0]   jr_addr_i,
  output logic [DATA_WIDTH-1:0]   pc_plus4_o,
  output logic [DATA_WIDTH-1:0]   next_pc_o,
  output logic                    misalign_o,
  output logic                    redirect_o
);

  pc_sel_t               sel;
  logic [DATA_WIDTH-1:0] brTarget;
  logic [DATA_WIDTH-1:0] jTarget;
  logic [DATA_WIDTH-1:0] jrTarget;

  assign pc_plus4_o = pc_i + DATA_WIDTH'(INSTR_BYTES);
  assign brTarget   = pc_plus4_o + (branch_offset_i << 2);
  assign jTarget    = {pc_plus4_o[DATA_WIDTH-1:28], jump_index_i, 2'b00};
  assign jrTarget   = {jr_addr_i[DATA_WIDTH-1:2], 2'b00};

  // Simultaneous redirects are legal; the highest priority one silently wins.
  always_comb begin
    sel = PC_SEL_SEQ;
    if (jump_reg_i) begin
      sel = PC_SEL_JR;
    end else if (jump_i) begin
      sel = PC_SEL_J;
    end else if (branch_taken_i) begin
      sel = PC_SEL_BR;
    end
  end

  always_comb begin
    next_pc_o = pc_plus4_o;
    if (stall_i) begin
      next_pc_o = pc_i;
    end else begin
      case (sel)
        PC_SEL_JR: next_pc_o = jrTarget;
        PC_SEL_J:  next_pc_o = jTarget;
        PC_SEL_BR: next_pc_o = brTarget;
        default:   next_pc_o = pc_plus4_o;
      endcase
    end
  end

  assign misalign_o = !stall_i && (sel == PC_SEL_JR) && (|jr_addr_i[1:0]);
  assign redirect_o = !stall_i && (sel != PC_SEL_SEQ);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter with stall hold, reset vector and sticky JR misalignment flag.
// Define PC_PERF_EN to add the retired/redirect performance counters.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
`ifdef PC_PERF_EN
  ,
  parameter int                    CNT_WIDTH    = 32
`endif
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pcPlus4;
  logic                  addrErr_q, addrErr_d;
  logic                  misalign;
  logic                  redirect;

  pc_next_sel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_next_sel (
    .pc_i           (pc_q),
    .stall_i        (bus.stall),
    .branch_taken_i (bus.branch_taken),
    .branch_offset_i(bus.branch_offset),
    .jump_i         (bus.jump),
    .jump_index_i   (bus.jump_index),
    .jump_reg_i     (bus.jump_reg),
    .jr_addr_i      (bus.jr_addr),
    .pc_plus4_o     (pcPlus4),
    .next_pc_o      (pc_d),
    .misalign_o     (misalign),
    .redirect_o     (redirect)
  );

  // The error flag only ever sets; it never stalls or diverts fetch.
  assign addrErr_d = addrErr_q | misalign;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_VECTOR;
      addrErr_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      addrErr_q <= addrErr_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.PC_plus4 = pcPlus4;
  assign bus.addr_err = addrErr_q;

`ifdef PC_PERF_EN
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [CNT_WIDTH-1:0] redirectCnt_q, redirectCnt_d;

  always_comb begin
    retired_d     = retired_q;
    redirectCnt_d = redirectCnt_q;
    if (!bus.stall) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end
    if (redirect) begin
      redirectCnt_d = redirectCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_q     <= '0;
      redirectCnt_q <= '0;
    end else begin
      retired_q     <= retired_d;
      redirectCnt_q <= redirectCnt_d;
    end
  end

  assign bus.retired_cnt  = retired_q;
  assign bus.redirect_cnt = redirectCnt_q;
`else
  logic unusedRedirect;
  assign unusedRedirect = redirect;
`endif

endmodule
